// File: rtl/jtag_ocimem_arbiter.sv
// rtl/jtag_ocimem_arbiter.sv - JTAG/CPU arbiter for the single-port debug monitor RAM
// Optional feature macro: OCIMEM_AUTOINC_EN (MonAReg post-increment after JTAG accesses).
module jtag_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              jrst_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_J_RD,
        S_J_RDW,
        S_J_WR,
        S_C_RD,
        S_C_RDW,
        S_C_WR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_mon_a_reg;
    logic [DATA_W-1:0] r_mon_d_reg;
    logic              r_monitor_ready;
    logic              r_monitor_error;
    logic [DATA_W-1:0] r_cpu_readdata;

    logic              r_pend_valid;
    logic              r_pend_wr;
    logic [DATA_W-1:0] r_pend_data;
    logic [ADDR_W-1:0] r_op_addr;
    logic [DATA_W-1:0] r_op_data;

`ifdef OCIMEM_AUTOINC_EN
    logic              r_ld_in_op;
`endif

    logic              w_ld;
    logic              w_jreq;
    logic              w_consume;
    logic              w_accept;
    logic              w_drop;
    logic              w_pend_valid_nxt;
    logic              w_jop_nxt;
    logic              w_unused;

    assign w_ld     = take_action_ocimem_a;
    assign w_jreq   = take_no_action_ocimem_a | take_action_ocimem_b
                    | (take_action_ocimem_a & jdo[25]);
    // The slot frees up in the same cycle IDLE hands its op to the FSM, so a pulse then is kept.
    assign w_consume = (r_state == S_IDLE) && r_pend_valid;
    assign w_accept  = w_jreq && (!r_pend_valid || w_consume);
    assign w_drop    = w_jreq && !w_accept;
    assign w_pend_valid_nxt = w_accept || (r_pend_valid && !w_consume);
    assign w_jop_nxt = (w_state_nxt == S_J_RD) || (w_state_nxt == S_J_RDW)
                     || (w_state_nxt == S_J_WR);

    assign w_unused = &{1'b0, jdo[37:35], jdo[2:0]};

    assign MonDReg       = r_mon_d_reg;
    assign monitor_ready = r_monitor_ready;
    assign monitor_error = r_monitor_error;

    always_comb begin
        w_state_nxt     = r_state;
        ram_we          = 1'b0;
        ram_addr        = '0;
        ram_wdata       = '0;
        cpu_waitrequest = 1'b1;
        cpu_readdata    = r_cpu_readdata;
        case (r_state)
            S_IDLE: begin
                if (r_pend_valid) begin
                    w_state_nxt = r_pend_wr ? S_J_WR : S_J_RD;
                end else if (cpu_write) begin
                    w_state_nxt = S_C_WR;
                end else if (cpu_read) begin
                    w_state_nxt = S_C_RD;
                end
            end
            S_J_RD: begin
                ram_addr    = r_op_addr;
                w_state_nxt = S_J_RDW;
            end
            S_J_RDW: begin
                w_state_nxt = S_IDLE;
            end
            S_J_WR: begin
                ram_we      = 1'b1;
                ram_addr    = r_op_addr;
                ram_wdata   = r_op_data;
                w_state_nxt = S_IDLE;
            end
            S_C_RD: begin
                ram_addr    = cpu_address;
                w_state_nxt = S_C_RDW;
            end
            S_C_RDW: begin
                // Forward RAM data so it is valid in the single cycle waitrequest is low.
                cpu_readdata    = ram_rdata;
                cpu_waitrequest = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            S_C_WR: begin
                ram_we          = 1'b1;
                ram_addr        = cpu_address;
                ram_wdata       = cpu_writedata;
                cpu_waitrequest = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge jrst_n) begin
        if (!jrst_n) begin
            r_state         <= S_IDLE;
            r_mon_a_reg     <= '0;
            r_mon_d_reg     <= '0;
            r_monitor_ready <= 1'b1;
            r_monitor_error <= 1'b0;
            r_cpu_readdata  <= '0;
            r_pend_valid    <= 1'b0;
            r_pend_wr       <= 1'b0;
            r_pend_data     <= '0;
            r_op_addr       <= '0;
            r_op_data       <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_monitor_ready <= !(w_pend_valid_nxt || w_jop_nxt);

            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_wr    <= take_action_ocimem_b;
                r_pend_data  <= jdo[3 +: DATA_W];
            end else if (w_consume) begin
                r_pend_valid <= 1'b0;
            end

            // The executing op keeps its own address and data, immune to later loads and pulses.
            if (w_consume) begin
                r_op_addr <= r_mon_a_reg;
                r_op_data <= r_pend_data;
            end

            if (w_drop) begin
                r_monitor_error <= 1'b1;
            end else if (w_ld && jdo[26]) begin
                r_monitor_error <= 1'b0;
            end

            if (r_state == S_J_RDW) begin
                r_mon_d_reg <= ram_rdata;
            end else if (r_state == S_J_WR) begin
                r_mon_d_reg <= r_op_data;
            end

            if (r_state == S_C_RDW) begin
                r_cpu_readdata <= ram_rdata;
            end

            if (w_ld) begin
                r_mon_a_reg <= jdo[17 +: ADDR_W];
`ifdef OCIMEM_AUTOINC_EN
            end else if (((r_state == S_J_RDW) || (r_state == S_J_WR)) && !r_ld_in_op) begin
                r_mon_a_reg <= r_op_addr + ADDR_W'(1);
`endif
            end
        end
    end

`ifdef OCIMEM_AUTOINC_EN
    // Remembers a load that landed while a JTAG op was in flight so its increment does not undo it.
    always_ff @(posedge clk or negedge jrst_n) begin
        if (!jrst_n) begin
            r_ld_in_op <= 1'b0;
        end else if (w_consume) begin
            r_ld_in_op <= w_ld;
        end else if (w_ld) begin
            r_ld_in_op <= 1'b1;
        end
    end
`endif

endmodule
